// File: rtl/s1d_host_if.sv
// Host bus front end for the S1D13700-compatible controller.
// It synchronises the 8080-style strobes and decodes each committed write
// as a command, a parameter, or a display-memory byte. Memory bytes are
// buffered in a small FIFO, and reads return a registered status or data byte.
module s1d_host_if #(
  parameter int             DW         = 8,
  parameter int             SYNC_STG   = 2,
  parameter int             MAX_PAR    = 16,
  parameter int             FIFO_DEPTH = 8,
  parameter logic [DW-1:0]  MWRITE_CMD = DW'(8'h42),
  localparam int            PIW        = (MAX_PAR > 1) ? $clog2(MAX_PAR) : 1
) (
  input  logic           P_MCLKI,
  input  logic           P_RST_X,
  input  logic           P_CE_X,
  input  logic           P_A0,
  input  logic           P_WR_X,
  input  logic           P_RD_X,
  input  logic [DW-1:0]  P_DI,
  output logic [DW-1:0]  P_DO,
  output logic           P_DOE,
  output logic [DW-1:0]  cmd_o,
  output logic           cmd_vld,
  output logic           par_we,
  output logic [PIW-1:0] par_idx,
  output logic [DW-1:0]  par_dat,
  output logic           mem_wvld,
  output logic [DW-1:0]  mem_wdat,
  input  logic           mem_wrdy,
  input  logic [DW-1:0]  rd_dat_i
);

  localparam int CW = $clog2(MAX_PAR + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PARAM, S_MWR} state_t;

  // Synchroniser chains, then the delay stage holding the previous sample
  logic [SYNC_STG-1:0] ce_sync_q, a0_sync_q, wr_sync_q;
  logic [DW-1:0]       di_sync_q [SYNC_STG];
  logic                ce_d_q, a0_d_q, wr_d_q;
  logic [DW-1:0]       di_d_q;

  // Strobes reset to their idle (high) level so reset release never looks like a WR rise
  always_ff @(posedge P_MCLKI or negedge P_RST_X) begin
    if (!P_RST_X) begin
      ce_sync_q <= '1;
      wr_sync_q <= '1;
      a0_sync_q <= '0;
      ce_d_q    <= 1'b1;
      wr_d_q    <= 1'b1;
      a0_d_q    <= 1'b0;
      di_d_q    <= '0;
    end else begin
      ce_sync_q <= {ce_sync_q[SYNC_STG-2:0], P_CE_X};
      wr_sync_q <= {wr_sync_q[SYNC_STG-2:0], P_WR_X};
      a0_sync_q <= {a0_sync_q[SYNC_STG-2:0], P_A0};
      ce_d_q    <= ce_sync_q[SYNC_STG-1];
      wr_d_q    <= wr_sync_q[SYNC_STG-1];
      a0_d_q    <= a0_sync_q[SYNC_STG-1];
      di_d_q    <= di_sync_q[SYNC_STG-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STG; gi++) begin : g_di_sync
      if (gi == 0) begin : g_first
        // First data stage samples the host pins
        always_ff @(posedge P_MCLKI or negedge P_RST_X) begin
          if (!P_RST_X) di_sync_q[gi] <= '0;
          else          di_sync_q[gi] <= P_DI;
        end
      end else begin : g_rest
        // Later data stages shift the previous one
        always_ff @(posedge P_MCLKI or negedge P_RST_X) begin
          if (!P_RST_X) di_sync_q[gi] <= '0;
          else          di_sync_q[gi] <= di_sync_q[gi-1];
        end
      end
    end
  endgenerate

  // Register the commit decision with A0/data captured from the delay stage (WR still low there)
  logic          commit_q, cmt_a0_q;
  logic [DW-1:0] cmt_dat_q;

  always_ff @(posedge P_MCLKI or negedge P_RST_X) begin
    if (!P_RST_X) begin
      commit_q  <= 1'b0;
      cmt_a0_q  <= 1'b0;
      cmt_dat_q <= '0;
    end else begin
      commit_q  <= wr_sync_q[SYNC_STG-1] & ~wr_d_q & ~ce_d_q;
      cmt_a0_q  <= a0_d_q;
      cmt_dat_q <= di_d_q;
    end
  end

  // Decoder state and registered outputs
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] cmd_q, cmd_d, par_dat_q, par_dat_d, push_dat_q, push_dat_d;
  logic [PIW-1:0] par_idx_q, par_idx_d;
  logic          cmd_vld_q, cmd_vld_d, par_we_q, par_we_d, push_q, push_d;
  logic          ovf_clr;

  // State register and output pulses
  always_ff @(posedge P_MCLKI or negedge P_RST_X) begin
    if (!P_RST_X) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      cmd_vld_q  <= 1'b0;
      par_we_q   <= 1'b0;
      par_idx_q  <= '0;
      par_dat_q  <= '0;
      push_q     <= 1'b0;
      push_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      cmd_vld_q  <= cmd_vld_d;
      par_we_q   <= par_we_d;
      par_idx_q  <= par_idx_d;
      par_dat_q  <= par_dat_d;
      push_q     <= push_d;
      push_dat_q <= push_dat_d;
    end
  end

  // Next-state decode: commands always win, data writes depend on the current mode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    cmd_vld_d  = 1'b0;
    par_we_d   = 1'b0;
    par_idx_d  = par_idx_q;
    par_dat_d  = par_dat_q;
    push_d     = 1'b0;
    push_dat_d = push_dat_q;
    ovf_clr    = 1'b0;
    if (commit_q) begin
      if (cmt_a0_q) begin
        cmd_d     = cmt_dat_q;
        cmd_vld_d = 1'b1;
        cnt_d     = '0;
        ovf_clr   = 1'b1;
        state_d   = (cmt_dat_q == MWRITE_CMD) ? S_MWR : S_PARAM;
      end else begin
        case (state_q)
          S_PARAM: begin
            // Excess parameters are dropped; the counter saturates at MAX_PAR
            if (cnt_q < CW'(MAX_PAR)) begin
              par_we_d  = 1'b1;
              par_idx_d = cnt_q[PIW-1:0];
              par_dat_d = cmt_dat_q;
              cnt_d     = cnt_q + 1'b1;
            end
          end
          S_MWR: begin
            push_d     = 1'b1;
            push_dat_d = cmt_dat_q;
          end
          default: ;
        endcase
      end
    end
  end

  // Memory-write FIFO
  logic [DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fcnt_q;
  logic          full, empty, do_push, do_pop, ovf_q;

  assign full    = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (fcnt_q == '0);
  assign do_push = push_q & ~full;
  assign do_pop  = ~empty & mem_wrdy;

  // Storage array, written only on accepted pushes
  always_ff @(posedge P_MCLKI) begin
    if (do_push) fifo_mem[wr_ptr_q] <= push_dat_q;
  end

  // Pointers, occupancy and sticky overflow (full is judged before any same-cycle pop)
  always_ff @(posedge P_MCLKI or negedge P_RST_X) begin
    if (!P_RST_X) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: ;
      endcase
      if (ovf_clr)             ovf_q <= 1'b0;
      else if (push_q && full) ovf_q <= 1'b1;
    end
  end

  // Read path: status byte for A0=1, memory data for A0=0
  logic [DW-1:0] status_w, do_q;

  always_comb begin
    status_w       = '0;
    status_w[DW-1] = ovf_q;
    status_w[DW-2] = ~empty;
  end

  // Read data register, refreshed every cycle from the synchronised A0
  always_ff @(posedge P_MCLKI or negedge P_RST_X) begin
    if (!P_RST_X) do_q <= '0;
    else          do_q <= a0_sync_q[SYNC_STG-1] ? status_w : rd_dat_i;
  end

  assign P_DO     = do_q;
  assign P_DOE    = ~P_CE_X & ~P_RD_X;
  assign cmd_o    = cmd_q;
  assign cmd_vld  = cmd_vld_q;
  assign par_we   = par_we_q;
  assign par_idx  = par_idx_q;
  assign par_dat  = par_dat_q;
  assign mem_wvld = ~empty;
  assign mem_wdat = empty ? '0 : fifo_mem[rd_ptr_q];

endmodule
